fetch_control: RTL

Sequencing controller for the instruction-fetch stage. Each cycle it produces the PC-source select and PC-enable (stall) that drive the fetch PC mux and PC register. It arbitrates between boot, interrupt entry, interrupt return, taken branches, pipeline hazards and instruction-memory wait states, and it owns the exception PC (EPC) and the interrupt-mask flag. It sits between decode/execute hazard and branch logic and the fetch stage.

---
 rtl/fetch_control_pkg.sv | 31 +++
 rtl/fetch_control_if.sv | 37 +++
 rtl/fetch_control_redirect_pending.sv | 54 +++++
 rtl/fetch_control.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/fetch_control_pkg.sv
// Shared definitions for the instruction-fetch sequencing controller.
//   - pc_sel encodings driving the fetch PC mux
//   - FSM state enum (BOOT / RUN / MEMWAIT)
//   - pending-redirect kind encoding and its mapping onto branch_src
package fetch_control_pkg;

  typedef logic [1:0] pc_sel_t;

  localparam pc_sel_t PCSEL_RESET  = 2'b00;
  localparam pc_sel_t PCSEL_INT    = 2'b01;
  localparam pc_sel_t PCSEL_SEQ    = 2'b10;
  localparam pc_sel_t PCSEL_BRANCH = 2'b11;

  typedef enum logic [1:0] {
    ST_BOOT    = 2'd0,
    ST_RUN     = 2'd1,
    ST_MEMWAIT = 2'd2
  } fsm_state_t;

  // Encoded so that the kind bit equals the branch_src value it needs
  // (0 = branch_target, 1 = epc).
  typedef enum logic {
    PEND_BRANCH = 1'b0,
    PEND_ERET   = 1'b1
  } pend_kind_t;

  function automatic logic src_of_kind(pend_kind_t kind);
    return (kind == PEND_ERET);
  endfunction

endpackage

// File: rtl/fetch_control_if.sv
// Bus between decode/execute/imem (master side) and the fetch controller
// (slave side).
//   master drives: pc, imem_ready, hazard_stall, branch_taken,
//                  branch_target, irq, eret
//   slave drives:  pc_sel, branch_src, stall, flush, epc, in_handler,
//                  pend_valid, pend_addr (held target of a deferred branch)
interface fetch_control_if;
  import fetch_control_pkg::*;

  logic [31:0] pc;
  logic        imem_ready;
  logic        hazard_stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        irq;
  logic        eret;

  pc_sel_t     pc_sel;
  logic        branch_src;
  logic        stall;
  logic        flush;
  logic [31:0] epc;
  logic        in_handler;
  logic        pend_valid;
  logic [31:0] pend_addr;

  modport master (
    output pc, imem_ready, hazard_stall, branch_taken, branch_target, irq, eret,
    input  pc_sel, branch_src, stall, flush, epc, in_handler, pend_valid, pend_addr
  );

  modport slave (
    input  pc, imem_ready, hazard_stall, branch_taken, branch_target, irq, eret,
    output pc_sel, branch_src, stall, flush, epc, in_handler, pend_valid, pend_addr
  );

endinterface

// File: rtl/fetch_control_redirect_pending.sv
// Holds a redirect (branch or eret) that arrives while fetch is waiting on
// instruction memory, so it can be applied once the word returns.
//   clk, reset       : clock, synchronous active-low reset
//   capture_en       : controller is in MEMWAIT; arrivals are captured
//   apply            : the pending redirect is being applied this cycle
//   eret, branch_taken, branch_target : redirect sources
//   pend_valid/kind/addr : registered pending redirect
//   eff_valid/kind   : pending redirect including this cycle's arrival
module fetch_control_redirect_pending
  import fetch_control_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        capture_en,
  input  logic        apply,
  input  logic        eret,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        pend_valid,
  output pend_kind_t  pend_kind,
  output logic [31:0] pend_addr,
  output logic        eff_valid,
  output pend_kind_t  eff_kind
);

  logic       arrive;
  pend_kind_t arrive_kind;

  assign arrive      = capture_en && (eret || branch_taken);
  // ERET wins when both show up in the same cycle.
  assign arrive_kind = eret ? PEND_ERET : PEND_BRANCH;

  // A same-cycle arrival is the newest capture, so it overrides the
  // registered one when the memory word returns in that very cycle.
  assign eff_valid = pend_valid || arrive;
  assign eff_kind  = arrive ? arrive_kind : pend_kind;

  always_ff @(posedge clk) begin
    if (!reset) begin
      pend_valid <= 1'b0;
      pend_kind  <= PEND_BRANCH;
      pend_addr  <= 32'd0;
    end else if (apply) begin
      pend_valid <= 1'b0;
    end else if (arrive) begin
      pend_valid <= 1'b1;
      pend_kind  <= arrive_kind;
      if (!eret) begin
        pend_addr <= branch_target;
      end
    end
  end

endmodule

// File: rtl/fetch_control.sv
// Instruction-fetch sequencing controller. Chooses the PC source and PC
// enable every cycle, arbitrating boot, interrupt entry/return, taken
// branches, decode hazards and imem wait states. Owns epc and in_handler.
//   clk, reset : clock, synchronous active-low reset
//   bus        : fetch_control_if.slave (inputs from pipeline, select/stall
//                outputs to the fetch PC mux and register)
module fetch_control
  import fetch_control_pkg::*;
#(
  parameter int BOOT_CYCLES = 4
) (
  input  logic            clk,
  input  logic            reset,
  fetch_control_if.slave  bus
);

  localparam int CNT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BOOT_CYCLES - 1);

  fsm_state_t       state;
  fsm_state_t       state_next;
  logic [CNT_W-1:0] boot_cnt;
  logic [31:0]      epc;
  logic             in_handler;

  pc_sel_t          pc_sel;
  logic             branch_src;
  logic             stall;
  logic             flush;

  logic             irq_ok;
  logic             take_irq;
  logic             clear_handler;
  logic             pend_apply;

  logic             pend_valid;
  pend_kind_t       pend_kind;
  logic [31:0]      pend_addr;
  logic             eff_valid;
  pend_kind_t       eff_kind;

  // Interrupts are only taken when the current word is present, so the
  // saved resume point refers to a real fetch.
  assign irq_ok = bus.irq && !in_handler && bus.imem_ready;

  fetch_control_redirect_pending u_pending (
    .clk           (clk),
    .reset         (reset),
    .capture_en    (state == ST_MEMWAIT),
    .apply         (pend_apply),
    .eret          (bus.eret),
    .branch_taken  (bus.branch_taken),
    .branch_target (bus.branch_target),
    .pend_valid    (pend_valid),
    .pend_kind     (pend_kind),
    .pend_addr     (pend_addr),
    .eff_valid     (eff_valid),
    .eff_kind      (eff_kind)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_BOOT;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_BOOT: begin
        if (boot_cnt == '0) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        // Only an otherwise-idle cycle that lacks the imem word waits.
        if (!bus.eret && !irq_ok && !bus.branch_taken &&
            !bus.hazard_stall && !bus.imem_ready) begin
          state_next = ST_MEMWAIT;
        end
      end
      ST_MEMWAIT: begin
        if (bus.imem_ready) begin
          state_next = ST_RUN;
        end
      end
      default: state_next = ST_BOOT;
    endcase
  end

  // Output logic (combinational for zero-cycle redirect)
  always_comb begin
    pc_sel        = PCSEL_SEQ;
    branch_src    = 1'b0;
    stall         = 1'b0;
    flush         = 1'b0;
    take_irq      = 1'b0;
    clear_handler = 1'b0;
    pend_apply    = 1'b0;
    if (!reset) begin
      pc_sel = PCSEL_RESET;
      flush  = 1'b1;
    end else begin
      case (state)
        ST_BOOT: begin
          pc_sel = PCSEL_RESET;
          flush  = 1'b1;
        end
        ST_RUN: begin
          if (bus.eret) begin
            pc_sel        = PCSEL_BRANCH;
            branch_src    = 1'b1;
            flush         = 1'b1;
            clear_handler = 1'b1;
          end else if (irq_ok) begin
            pc_sel   = PCSEL_INT;
            flush    = 1'b1;
            take_irq = 1'b1;
          end else if (bus.branch_taken) begin
            pc_sel = PCSEL_BRANCH;
            flush  = 1'b1;
          end else if (bus.hazard_stall || !bus.imem_ready) begin
            stall = 1'b1;
          end
        end
        ST_MEMWAIT: begin
          if (bus.imem_ready && eff_valid) begin
            pc_sel        = PCSEL_BRANCH;
            branch_src    = src_of_kind(eff_kind);
            flush         = 1'b1;
            pend_apply    = 1'b1;
            clear_handler = (eff_kind == PEND_ERET);
          end else if (!bus.imem_ready) begin
            stall = 1'b1;
          end
        end
        default: begin
          pc_sel = PCSEL_RESET;
          flush  = 1'b1;
        end
      endcase
    end
  end

  // Boot counter, exception PC and interrupt mask
  always_ff @(posedge clk) begin
    if (!reset) begin
      boot_cnt   <= CNT_LOAD;
      epc        <= 32'd0;
      in_handler <= 1'b0;
    end else begin
      if (state == ST_BOOT && boot_cnt != '0) begin
        boot_cnt <= boot_cnt - CNT_W'(1);
      end
      if (take_irq) begin
        // A branch resolving alongside the interrupt is the true next PC.
        epc        <= bus.branch_taken ? bus.branch_target : bus.pc;
        in_handler <= 1'b1;
      end else if (clear_handler) begin
        in_handler <= 1'b0;
      end
    end
  end

  assign bus.pc_sel     = pc_sel;
  assign bus.branch_src = branch_src;
  assign bus.stall      = stall;
  assign bus.flush      = flush;
  assign bus.epc        = epc;
  assign bus.in_handler = in_handler;
  assign bus.pend_valid = pend_valid;
  assign bus.pend_addr  = pend_addr;

endmodule
